cdb_arbiter: RTL

//  Common-data-bus arbiter: shares the single result broadcast bus (consumed by RS, LSB, ROB)

---
 rtl/cdb_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one FIFO per producing unit, round-robin grant of one
// result per cycle onto a registered broadcast port; flushed on ROB rollback.
module cdb_arbiter #(
    parameter int N_SRC  = 2,
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy_in,
    input  logic                       rollback_in,
    input  logic [N_SRC-1:0]           src_valid_in,
    input  logic [N_SRC*WORD_W-1:0]    src_result_in,
    input  logic [N_SRC*TAG_W-1:0]     src_tag_in,
    output logic [N_SRC-1:0]           src_full_out,
    output logic                       broadcast_signal_out,
    output logic [WORD_W-1:0]          result_out,
    output logic [TAG_W-1:0]           dest_tag_out,
    output logic [$clog2(N_SRC)-1:0]   grant_src_out,
    output logic                       overflow_out
);

    localparam int SRC_W = $clog2(N_SRC);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WORD_W-1:0] mem_result [N_SRC][DEPTH];
    logic [TAG_W-1:0]  mem_tag    [N_SRC][DEPTH];
    logic [PTR_W-1:0]  rd_ptr     [N_SRC];
    logic [PTR_W-1:0]  wr_ptr     [N_SRC];
    logic [CNT_W-1:0]  count      [N_SRC];
    logic [SRC_W-1:0]  rr;

    logic [N_SRC-1:0]  has_head;
    logic [N_SRC-1:0]  cand;
    logic [N_SRC-1:0]  pop;
    logic [N_SRC-1:0]  push;
    logic [N_SRC-1:0]  drop;
    logic [WORD_W-1:0] cand_result [N_SRC];
    logic [TAG_W-1:0]  cand_tag    [N_SRC];
    logic              grant_any;
    logic [SRC_W-1:0]  grant_idx;
    logic [SRC_W-1:0]  rr_next;

    // A source with an empty FIFO offers its incoming result directly (bypass).
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            has_head[i]    = (count[i] != '0);
            cand[i]        = has_head[i] | src_valid_in[i];
            cand_result[i] = has_head[i] ? mem_result[i][rd_ptr[i]]
                                         : src_result_in[i*WORD_W +: WORD_W];
            cand_tag[i]    = has_head[i] ? mem_tag[i][rd_ptr[i]]
                                         : src_tag_in[i*TAG_W +: TAG_W];
        end
    end

    always_comb begin
        int idx;
        int nxt;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = int'(rr) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (!grant_any && cand[idx]) begin
                grant_any = 1'b1;
                grant_idx = SRC_W'(idx);
            end
        end
        nxt = int'(grant_idx) + 1;
        if (nxt >= N_SRC) nxt = 0;
        rr_next = SRC_W'(nxt);
    end

    // A granted bypass consumes the incoming result, so it is never stored.
    always_comb begin
        logic granted;
        logic push_req;
        logic full;
        granted  = 1'b0;
        push_req = 1'b0;
        full     = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            granted         = grant_any && (grant_idx == SRC_W'(i));
            full            = (count[i] == CNT_W'(DEPTH));
            pop[i]          = granted && has_head[i];
            push_req        = src_valid_in[i] && !(granted && !has_head[i]);
            push[i]         = push_req && (!full || pop[i]);
            drop[i]         = push_req && full && !pop[i];
            src_full_out[i] = full;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy_in && !rollback_in) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (push[i]) begin
                    mem_result[i][wr_ptr[i]] <= src_result_in[i*WORD_W +: WORD_W];
                    mem_tag[i][wr_ptr[i]]    <= src_tag_in[i*TAG_W +: TAG_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr                   <= '0;
            broadcast_signal_out <= 1'b0;
            result_out           <= '0;
            dest_tag_out         <= '0;
            grant_src_out        <= '0;
            overflow_out         <= 1'b0;
        end else if (rdy_in) begin
            if (rollback_in) begin
                for (int i = 0; i < N_SRC; i++) begin
                    rd_ptr[i] <= '0;
                    wr_ptr[i] <= '0;
                    count[i]  <= '0;
                end
                rr                   <= '0;
                broadcast_signal_out <= 1'b0;
            end else begin
                for (int i = 0; i < N_SRC; i++) begin
                    if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                    if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                    case ({push[i], pop[i]})
                        2'b10:   count[i] <= count[i] + CNT_W'(1);
                        2'b01:   count[i] <= count[i] - CNT_W'(1);
                        default: count[i] <= count[i];
                    endcase
                end
                if (|drop) overflow_out <= 1'b1;
                if (grant_any) begin
                    broadcast_signal_out <= 1'b1;
                    result_out           <= cand_result[grant_idx];
                    dest_tag_out         <= cand_tag[grant_idx];
                    grant_src_out        <= grant_idx;
                    rr                   <= rr_next;
                end else begin
                    broadcast_signal_out <= 1'b0;
                end
            end
        end
    end

endmodule
